// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the default tone table (terminal counts)
// and the default ms prescaler divide ratio for a 25 MHz board clock.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // Clock cycles per 1 ms tick at 25 MHz.
    localparam int TICK_DIV = 25_000;

    // Tone counter width; must hold the largest table entry.
    localparam int TONE_W = 20;

    // Terminal counts, element [i] is tone_sel == i.
    // [0] 25 Hz click, [1] 440 Hz, [2] 1 kHz, [3] 2 kHz.
    localparam logic [3:0][TONE_W-1:0] TONE_TC = {
        20'd12_499,
        20'd24_999,
        20'd56_817,
        20'd999_999
    };

endpackage

// File: rtl/beep_pattern_gen_if.sv
// Control/status bundle between board control logic and the buzzer driver.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored by the driver while busy is high.
//
// master: control side (drives start/abort/settings, observes status).
// slave : buzzer driver (consumes settings, drives busy/done/beep).
interface beep_pattern_gen_if #(
    parameter int MS_W  = 16,
    parameter int REP_W = 4
) ();

    logic             start;
    logic             abort;
    logic [1:0]       tone_sel;
    logic [MS_W-1:0]  on_ms;
    logic [MS_W-1:0]  off_ms;
    logic [REP_W-1:0] repeat_n;
    logic             busy;
    logic             done;
    logic             beep;

    modport master (
        output start, abort, tone_sel, on_ms, off_ms, repeat_n,
        input  busy, done, beep
    );

    modport slave (
        input  start, abort, tone_sel, on_ms, off_ms, repeat_n,
        output busy, done, beep
    );

endinterface

// File: rtl/beep_pattern_gen_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Latency: first tick on the TICK_DIV-th enabled cycle after a clear.
// Backpressure: none; holds its count while en_i is low.
//
// Ports: clk_i/rst_ni clock and async active-low reset; en_i counts;
// clr_i synchronously zeroes the count (wins over en_i); tick_o pulse.
module ms_tick_gen #(
    parameter int TICK_DIV = 25_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/beep_pattern_gen.sv
// Buzzer driver: square-wave tone generator plus on/off burst sequencer.
// Latency: busy rises the edge start is sampled; beep follows one edge later.
// Backpressure: start is ignored while busy; abort ends a burst next edge.
//
// Ports: ext_clk_25m system clock; ext_rst_n async active-low reset;
// bus (slave) carries start/abort/tone_sel/on_ms/off_ms/repeat_n in and
// busy/done/beep out. MS_W/REP_W must match the connected interface.
module beep_pattern_gen #(
    parameter int                         TICK_DIV = beep_pkg::TICK_DIV,
    parameter int                         MS_W     = 16,
    parameter int                         REP_W    = 4,
    parameter int                         TONE_W   = beep_pkg::TONE_W,
    parameter logic [3:0][TONE_W-1:0]     TONE_TC  = beep_pkg::TONE_TC
) (
    input  logic                ext_clk_25m,
    input  logic                ext_rst_n,
    beep_pattern_gen_if.slave   bus
);

    import beep_pkg::*;

    state_t            state_q, state_d;
    logic [TONE_W-1:0] tc_q;
    logic [TONE_W:0]   half_q;          // (TC+1)/2, one bit wider so TC+1 cannot wrap
    logic [MS_W-1:0]   on_len_q;
    logic [MS_W-1:0]   off_len_q;
    logic [REP_W-1:0]  rep_q;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [REP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              beep_q, beep_d;
    logic              done_q, done_d;
    logic              latch;
    logic              tick;
    logic [TONE_W-1:0] sel_tc;
    logic [TONE_W:0]   sel_half;

    // Prescaler only runs during a burst and restarts on every accepted start,
    // so every phase boundary lands on a tick boundary.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick (
        .clk_i  (ext_clk_25m),
        .rst_ni (ext_rst_n),
        .en_i   (state_q != ST_IDLE),
        .clr_i  (latch),
        .tick_o (tick)
    );

    assign sel_tc   = TONE_TC[bus.tone_sel];
    assign sel_half = ({1'b0, sel_tc} + (TONE_W+1)'(1)) >> 1;

    always_comb begin
        state_d    = state_q;
        ms_cnt_d   = ms_cnt_q;
        beep_cnt_d = beep_cnt_q;
        tone_cnt_d = '0;
        done_d     = 1'b0;
        latch      = 1'b0;
        // Output lags the state by one edge: high half of the tone period.
        beep_d     = (state_q == ST_ON) && ({1'b0, tone_cnt_q} < half_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d    = ST_ON;
                    latch      = 1'b1;
                    ms_cnt_d   = '0;
                    beep_cnt_d = '0;
                end
            end
            ST_ON: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    ms_cnt_d = '0;
                    beep_d   = 1'b0;
                end else if (tick && (ms_cnt_q == on_len_q - MS_W'(1))) begin
                    // End of ON phase; tone counter restarts whatever comes next.
                    ms_cnt_d   = '0;
                    beep_cnt_d = beep_cnt_q + REP_W'(1);
                    if ((rep_q != '0) && (beep_cnt_d == rep_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (off_len_q == '0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    if (tick) begin
                        ms_cnt_d = ms_cnt_q + MS_W'(1);
                    end
                    tone_cnt_d = (tone_cnt_q == tc_q) ? '0 : tone_cnt_q + TONE_W'(1);
                end
            end
            ST_OFF: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    ms_cnt_d = '0;
                    beep_d   = 1'b0;
                end else if (tick && (ms_cnt_q == off_len_q - MS_W'(1))) begin
                    state_d  = ST_ON;
                    ms_cnt_d = '0;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + MS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q    <= ST_IDLE;
            tc_q       <= '0;
            half_q     <= '0;
            on_len_q   <= '0;
            off_len_q  <= '0;
            rep_q      <= '0;
            ms_cnt_q   <= '0;
            beep_cnt_q <= '0;
            tone_cnt_q <= '0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_cnt_q   <= ms_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            beep_q     <= beep_d;
            done_q     <= done_d;
            if (latch) begin
                tc_q      <= sel_tc;
                half_q    <= sel_half;
                // A zero-length ON phase is played as 1 ms.
                on_len_q  <= (bus.on_ms == '0) ? MS_W'(1) : bus.on_ms;
                off_len_q <= bus.off_ms;
                rep_q     <= bus.repeat_n;
            end
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.beep = beep_q;

endmodule
